// File: rtl/ping_pong_monitor.sv
// ping_pong_monitor: tracks a ping-pong counter against a reference model, flags faults, counts bounces.
// Defining PP_MONITOR_CAPTURE_EN adds capture of the expected/observed values at the first mismatch.
module ping_pong_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             pp_rst,
  input  logic             pp_enable,
  input  logic             pp_flip,
  input  logic [WIDTH-1:0] pp_max,
  input  logic [WIDTH-1:0] pp_min,
  input  logic [WIDTH-1:0] pp_out,
  input  logic             pp_dir,
  output logic             mismatch,
  output logic             fault,
  output logic [1:0]       err_code,
  output logic             locked,
  output logic [CNT_W-1:0] bounce_cnt,
  output logic [CNT_W-1:0] flip_cnt
`ifdef PP_MONITOR_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] cap_exp_out,
  output logic             cap_exp_dir,
  output logic [WIDTH-1:0] cap_obs_out,
  output logic             cap_obs_dir
`endif
);
  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] exp_out, m_out;
  logic exp_dir, m_dir, prev_dir, flip_prev, active, turn, flip_rev, miss, cnt_en;
  logic [1:0] diff;
  // the counter only moves when enabled inside a legal, non-degenerate range
  assign active = !pp_rst && pp_enable && pp_min < pp_max && pp_min <= pp_out && pp_out <= pp_max;
  assign turn = pp_flip || (pp_dir ? pp_out == pp_max : pp_out == pp_min);
  assign flip_rev = active && pp_flip;
  assign m_dir = pp_rst ? 1'b1 : active ? pp_dir ^ turn : pp_dir;
  assign m_out = pp_rst ? pp_min : !active ? pp_out : m_dir ? pp_out + WIDTH'(1) : pp_out - WIDTH'(1);
  assign locked = state == TRACK;
  always_comb begin
    diff = {pp_dir != exp_dir, pp_out != exp_out};
    miss = state == TRACK && diff != 2'b00 && !clear;
    cnt_en = state == TRACK && !clear;
    state_nx = clear ? SYNC : miss ? FAULT : state == SYNC ? TRACK : state;
  end
  always_ff @(posedge clk) begin
    prev_dir <= pp_dir;
    flip_prev <= flip_rev;
    if (rst) begin
      state <= SYNC;
      exp_out <= '0;
      exp_dir <= 1'b1;
      mismatch <= 1'b0;
      fault <= 1'b0;
      err_code <= 2'b00;
      bounce_cnt <= '0;
      flip_cnt <= '0;
    end else begin
      state <= state_nx;
      exp_out <= m_out;
      exp_dir <= m_dir;
      mismatch <= miss;
      fault <= !clear && (fault || miss);
      err_code <= clear ? 2'b00 : miss ? diff : err_code;
      bounce_cnt <= clear ? '0 : bounce_cnt + CNT_W'(cnt_en && pp_dir != prev_dir && bounce_cnt != '1);
      flip_cnt <= clear ? '0 : flip_cnt + CNT_W'(cnt_en && flip_prev && flip_cnt != '1);
    end
  end
`ifdef PP_MONITOR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cap_exp_out <= '0;
      cap_exp_dir <= 1'b0;
      cap_obs_out <= '0;
      cap_obs_dir <= 1'b0;
    end else if (miss) begin
      cap_exp_out <= exp_out;
      cap_exp_dir <= exp_dir;
      cap_obs_out <= pp_out;
      cap_obs_dir <= pp_dir;
    end
  end
`endif
endmodule
